// File: rtl/bitty_pkg.sv
// Shared definitions for the bitty sequencer: opcodes, branch conditions,
// instruction field positions and the sequencer state encoding.
// Ports: none (package only).
package bitty_pkg;

  // Default widths for the sequencer datapath.
  localparam int ADDR_W_DEF  = 8;
  localparam int INSTR_W_DEF = 16;
  localparam int DATA_W_DEF  = 16;

  // Opcodes that are resolved by the sequencer itself rather than the ALU.
  localparam logic [1:0] OP_BRANCH = 2'd2;
  localparam logic [1:0] OP_RSVD   = 2'd3;

  // Branch condition codes, compared against the last ALU result.
  localparam logic [1:0] COND_EQ0   = 2'd0;
  localparam logic [1:0] COND_EQ1   = 2'd1;
  localparam logic [1:0] COND_EQ2   = 2'd2;
  localparam logic [1:0] COND_NEVER = 2'd3;

  // Instruction field slices: opcode [1:0], cond [3:2], target [11:4].
  localparam int OPC_LSB  = 0;
  localparam int OPC_W    = 2;
  localparam int COND_LSB = 2;
  localparam int COND_W   = 2;
  localparam int TGT_LSB  = 4;
  localparam int TGT_W    = 8;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EXEC,
    WB,
    BRANCH
  } state_t;

  // Both branch and reserved opcodes bypass the ALU and go through BRANCH.
  function automatic logic is_branch_class(input logic [OPC_W-1:0] opc);
    return (opc == OP_BRANCH) || (opc == OP_RSVD);
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch and ALU handshake bundle between the sequencer and its neighbours.
// master = sequencer side (drives req/addr/start/we), slave = memory/ALU side.
// Signals: imem_req/addr/valid/data (fetch), alu_start/done/result, reg_we.
interface pc_sequencer_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16,
  parameter int DATA_W  = 16
);

  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_valid;
  logic [INSTR_W-1:0] imem_data;
  logic               alu_start;
  logic               alu_done;
  logic [DATA_W-1:0]  alu_result;
  logic               reg_we;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_valid,
    input  imem_data,
    output alu_start,
    input  alu_done,
    input  alu_result,
    output reg_we
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_valid,
    output imem_data,
    input  alu_start,
    output alu_done,
    output alu_result,
    input  reg_we
  );

endinterface

// File: rtl/pc_sequencer_branch_resolve.sv
// Next-PC computation for a conditional branch held in the IR.
// Latency: combinational. Backpressure: none.
// Ports: pc, ir, last_alu_result in; next_pc out (target if taken, else pc+1).
module branch_resolve
  import bitty_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic [ADDR_W-1:0]  pc,
  input  logic [INSTR_W-1:0] ir,
  input  logic [DATA_W-1:0]  last_alu_result,
  output logic [ADDR_W-1:0]  next_pc
);

  logic [OPC_W-1:0]  opc;
  logic [COND_W-1:0] cond;
  logic [TGT_W-1:0]  target;
  logic              taken;

  assign opc    = ir[OPC_LSB  +: OPC_W];
  assign cond   = ir[COND_LSB +: COND_W];
  assign target = ir[TGT_LSB  +: TGT_W];

  // Upper IR bits carry no branch information.
  logic unused_ir_hi;
  assign unused_ir_hi = ^ir[INSTR_W-1:TGT_LSB+TGT_W];

  // Full-width compare: a result of 0x0101 must not satisfy "equals 1".
  // Only the real branch opcode can be taken; the reserved one falls to pc+1.
  always_comb begin
    taken = 1'b0;
    if (opc == OP_BRANCH) begin
      case (cond)
        COND_EQ0:   taken = (last_alu_result == DATA_W'(0));
        COND_EQ1:   taken = (last_alu_result == DATA_W'(1));
        COND_EQ2:   taken = (last_alu_result == DATA_W'(2));
        COND_NEVER: taken = 1'b0;
        default:    taken = 1'b0;
      endcase
    end
  end

  // pc+1 wraps naturally at 2^ADDR_W; the target is zero-extended.
  assign next_pc = taken ? ADDR_W'(target) : (pc + ADDR_W'(1));

endmodule

// File: rtl/pc_sequencer.sv
// Instruction sequencer: owns the PC, fetches, starts the ALU, writes back, branches.
// Latency: non-branch = fetch wait + 1 + ALU wait + 1; branch = fetch wait + 1.
// Backpressure: imem_req held until imem_valid; EXEC waits on alu_done indefinitely.
// Ports: clk, reset (async, active high), run; bus (master side of
// pc_sequencer_if); instr (IR), last_alu_result, pc, busy.
module pc_sequencer
  import bitty_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  pc_sequencer_if.master     bus,
  output logic [INSTR_W-1:0] instr,
  output logic [DATA_W-1:0]  last_alu_result,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy
);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0]  last_q, last_d;
  // Marks the first EXEC cycle: drives alu_start and masks alu_done.
  logic               start_q, start_d;

  logic               fetch_is_branch;
  logic [ADDR_W-1:0]  br_next_pc;

  assign fetch_is_branch = is_branch_class(bus.imem_data[OPC_LSB +: OPC_W]);

  branch_resolve #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W),
    .DATA_W  (DATA_W)
  ) u_branch_resolve (
    .pc              (pc_q),
    .ir              (ir_q),
    .last_alu_result (last_q),
    .next_pc         (br_next_pc)
  );

  // ---------------------------------------------------------------- FSM state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------- FSM next
  // run is only looked at in IDLE, WB and BRANCH, so dropping it mid-instruction
  // lets the current instruction finish before parking in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (run) state_d = FETCH;
      end
      FETCH: begin
        if (bus.imem_valid) state_d = fetch_is_branch ? BRANCH : EXEC;
      end
      EXEC: begin
        if (bus.alu_done && !start_q) state_d = WB;
      end
      WB: begin
        state_d = run ? FETCH : IDLE;
      end
      BRANCH: begin
        state_d = run ? FETCH : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------- FSM outputs
  // Decoded straight from registered state so an async reset clears them at once.
  always_comb begin
    bus.imem_req  = (state_q == FETCH);
    bus.imem_addr = pc_q;
    bus.alu_start = (state_q == EXEC) && start_q;
    bus.reg_we    = (state_q == WB);
    busy          = (state_q != IDLE);
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= '0;
      ir_q    <= '0;
      last_q  <= '0;
      start_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      last_q  <= last_d;
      start_q <= start_d;
    end
  end

  always_comb begin
    pc_d    = pc_q;
    ir_d    = ir_q;
    last_d  = last_q;
    start_d = 1'b0;
    case (state_q)
      FETCH: begin
        if (bus.imem_valid) begin
          ir_d    = bus.imem_data;
          start_d = !fetch_is_branch;
        end
      end
      EXEC: begin
        // A done that coincides with the start pulse belongs to nothing we issued.
        if (bus.alu_done && !start_q) last_d = bus.alu_result;
      end
      WB: begin
        pc_d = pc_q + ADDR_W'(1);
      end
      BRANCH: begin
        pc_d = br_next_pc;
      end
      default: begin
        pc_d = pc_q;
      end
    endcase
  end

  assign instr           = ir_q;
  assign last_alu_result = last_q;
  assign pc              = pc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a table of whole instructions with
// hand-computed PC / result / pulse / cycle expectations, followed by
// hand-written sequences for start-cycle done, reset mid-EXEC and run drop.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [15:0] instr;
  logic [15:0] last_alu_result;
  logic [7:0]  pc;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;
  int tot_start = 0;
  int tot_we = 0;

  always #5 clk = ~clk;

  pc_sequencer_if #(.ADDR_W(8), .INSTR_W(16), .DATA_W(16)) bus ();

  pc_sequencer #(.ADDR_W(8), .INSTR_W(16), .DATA_W(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .run             (run),
    .bus             (bus),
    .instr           (instr),
    .last_alu_result (last_alu_result),
    .pc              (pc),
    .busy            (busy)
  );

  // Pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.alu_start) tot_start = tot_start + 1;
    if (bus.reg_we)    tot_we    = tot_we + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, required finish before 100us");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Runs one instruction from the fetch through return to FETCH or IDLE.
  task automatic do_instr(input logic [15:0] word, input int fwait,
                          input logic [15:0] ares, input int await,
                          output int cyc, output int n_st, output int n_we);
    int  s0;
    int  w0;
    int  k;
    bit  is_br;
    s0    = tot_start;
    w0    = tot_we;
    cyc   = 0;
    is_br = word[1];
    k     = 0;
    while (!bus.imem_req && k < 20) begin
      tick();
      k++;
    end
    chk("imem_req_seen", {31'd0, bus.imem_req}, 32'd1);
    repeat (fwait) begin
      tick();
      cyc++;
    end
    bus.imem_valid = 1'b1;
    bus.imem_data  = word;
    tick();
    cyc++;
    bus.imem_valid = 1'b0;
    bus.imem_data  = 16'h0000;
    if (!is_br) begin
      repeat (await) begin
        tick();
        cyc++;
      end
      bus.alu_done   = 1'b1;
      bus.alu_result = ares;
      tick();
      cyc++;
      bus.alu_done   = 1'b0;
      bus.alu_result = 16'h0000;
    end
    k = 0;
    do begin
      tick();
      cyc++;
      k++;
    end while (!(bus.imem_req || !busy) && k < 20);
    n_st = tot_start - s0;
    n_we = tot_we - w0;
  endtask

  typedef struct {
    logic [15:0] word;
    int          fwait;
    logic [15:0] ares;
    int          await;
    logic [7:0]  exp_pc;
    logic [15:0] exp_last;
  } vec_t;

  localparam int NV = 19;
  vec_t tbl[NV];

  initial begin
    int cyc;
    int n_st;
    int n_we;
    int exp_cyc;
    bit is_br;

    //            word      fw  ares      aw  pc     last
    tbl[0]  = '{16'h0001, 2, 16'h0000, 3, 8'h01, 16'h0000};
    tbl[1]  = '{16'h0502, 1, 16'h0000, 1, 8'h50, 16'h0000}; // cond0 taken
    tbl[2]  = '{16'h0011, 0, 16'h0003, 1, 8'h51, 16'h0003};
    tbl[3]  = '{16'h0502, 0, 16'h0000, 1, 8'h52, 16'h0003}; // cond0 not taken
    tbl[4]  = '{16'h0000, 1, 16'h0002, 2, 8'h53, 16'h0002};
    tbl[5]  = '{16'h00AA, 0, 16'h0000, 1, 8'h0A, 16'h0002}; // cond2 taken
    tbl[6]  = '{16'h00AE, 3, 16'h0000, 1, 8'h0B, 16'h0002}; // cond3 never
    tbl[7]  = '{16'h0005, 0, 16'h0101, 1, 8'h0C, 16'h0101};
    tbl[8]  = '{16'h0206, 0, 16'h0000, 1, 8'h0D, 16'h0101}; // cond1, 0x0101 != 1
    tbl[9]  = '{16'h0000, 1, 16'h0001, 1, 8'h0E, 16'h0001};
    tbl[10] = '{16'h0206, 0, 16'h0000, 1, 8'h20, 16'h0001}; // cond1 taken
    tbl[11] = '{16'h0000, 0, 16'h0000, 1, 8'h21, 16'h0000};
    tbl[12] = '{16'h0FF2, 0, 16'h0000, 1, 8'hFF, 16'h0000}; // jump to 0xFF
    tbl[13] = '{16'h0001, 1, 16'h0000, 2, 8'h00, 16'h0000}; // pc wraps
    tbl[14] = '{16'h0FF2, 0, 16'h0000, 1, 8'hFF, 16'h0000};
    tbl[15] = '{16'hFF03, 1, 16'h0000, 1, 8'h00, 16'h0000}; // reserved wraps
    tbl[16] = '{16'h0FF3, 0, 16'h0000, 1, 8'h01, 16'h0000}; // reserved never jumps
    tbl[17] = '{16'h0000, 0, 16'h0100, 1, 8'h02, 16'h0100};
    tbl[18] = '{16'h0502, 0, 16'h0000, 1, 8'h03, 16'h0100}; // 0x0100 != 0

    reset          = 1'b1;
    run            = 1'b0;
    bus.imem_valid = 1'b0;
    bus.imem_data  = 16'h0000;
    bus.alu_done   = 1'b0;
    bus.alu_result = 16'h0000;

    // Reset state
    tick();
    tick();
    run = 1'b1;
    tick();
    chk("rst_pc",    {24'd0, pc}, 32'h0);
    chk("rst_instr", {16'd0, instr}, 32'h0);
    chk("rst_last",  {16'd0, last_alu_result}, 32'h0);
    chk("rst_busy",  {31'd0, busy}, 32'h0);
    chk("rst_req",   {31'd0, bus.imem_req}, 32'h0);
    chk("rst_start", {31'd0, bus.alu_start}, 32'h0);
    chk("rst_we",    {31'd0, bus.reg_we}, 32'h0);
    reset = 1'b0;

    // Instruction table, run held high throughout
    for (int i = 0; i < NV; i++) begin
      do_instr(tbl[i].word, tbl[i].fwait, tbl[i].ares, tbl[i].await, cyc, n_st, n_we);
      is_br   = tbl[i].word[1];
      exp_cyc = is_br ? (tbl[i].fwait + 1 + 1)
                      : (tbl[i].fwait + 1 + tbl[i].await + 1 + 1);
      chk($sformatf("v%0d_pc", i),    {24'd0, pc}, {24'd0, tbl[i].exp_pc});
      chk($sformatf("v%0d_addr", i),  {24'd0, bus.imem_addr}, {24'd0, tbl[i].exp_pc});
      chk($sformatf("v%0d_last", i),  {16'd0, last_alu_result}, {16'd0, tbl[i].exp_last});
      chk($sformatf("v%0d_instr", i), {16'd0, instr}, {16'd0, tbl[i].word});
      chk($sformatf("v%0d_starts", i), n_st, is_br ? 0 : 1);
      chk($sformatf("v%0d_wes", i),    n_we, is_br ? 0 : 1);
      chk($sformatf("v%0d_cycles", i), cyc, exp_cyc);
    end

    // alu_done coinciding with the start pulse must be ignored (pc 3)
    bus.imem_valid = 1'b1;
    bus.imem_data  = 16'h0001;
    tick();
    bus.imem_valid = 1'b0;
    chk("early_start", {31'd0, bus.alu_start}, 32'h1);
    bus.alu_done   = 1'b1;
    bus.alu_result = 16'hBAD0;
    tick();
    chk("early_busy",  {31'd0, busy}, 32'h1);
    chk("early_we",    {31'd0, bus.reg_we}, 32'h0);
    chk("early_start2", {31'd0, bus.alu_start}, 32'h0);
    bus.alu_result = 16'h0042;
    tick();
    bus.alu_done = 1'b0;
    chk("early_we2",  {31'd0, bus.reg_we}, 32'h1);
    chk("early_last", {16'd0, last_alu_result}, 32'h0042);
    tick();
    chk("early_pc",   {24'd0, pc}, 32'h04);
    chk("early_addr", {24'd0, bus.imem_addr}, 32'h04);

    // Reset mid-EXEC with alu_done pending (pc 4)
    bus.imem_valid = 1'b1;
    bus.imem_data  = 16'h0001;
    tick();
    bus.imem_valid = 1'b0;
    tick();
    bus.alu_done   = 1'b1;
    bus.alu_result = 16'h5555;
    #1;
    reset = 1'b1;
    #1;
    chk("mrst_pc",    {24'd0, pc}, 32'h0);
    chk("mrst_busy",  {31'd0, busy}, 32'h0);
    chk("mrst_start", {31'd0, bus.alu_start}, 32'h0);
    chk("mrst_we",    {31'd0, bus.reg_we}, 32'h0);
    chk("mrst_req",   {31'd0, bus.imem_req}, 32'h0);
    chk("mrst_last",  {16'd0, last_alu_result}, 32'h0);
    chk("mrst_instr", {16'd0, instr}, 32'h0);
    run = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    tick();
    chk("mrst_last_after", {16'd0, last_alu_result}, 32'h0);
    chk("mrst_busy_after", {31'd0, busy}, 32'h0);
    chk("mrst_we_after",   {31'd0, bus.reg_we}, 32'h0);
    bus.alu_done   = 1'b0;
    bus.alu_result = 16'h0000;

    // run dropped during the fetch wait: instruction completes, then IDLE
    run = 1'b1;
    tick();
    chk("rd_req",  {31'd0, bus.imem_req}, 32'h1);
    chk("rd_addr", {24'd0, bus.imem_addr}, 32'h0);
    run = 1'b0;
    do_instr(16'h0001, 2, 16'h0007, 2, cyc, n_st, n_we);
    chk("rd_cycles", cyc, 7);
    chk("rd_pc",     {24'd0, pc}, 32'h01);
    chk("rd_last",   {16'd0, last_alu_result}, 32'h0007);
    chk("rd_busy",   {31'd0, busy}, 32'h0);
    chk("rd_req_off", {31'd0, bus.imem_req}, 32'h0);
    chk("rd_starts", n_st, 1);
    chk("rd_wes",    n_we, 1);
    tick();
    tick();
    chk("rd_idle_hold", {31'd0, busy}, 32'h0);
    run = 1'b1;
    tick();
    chk("rd_resume_req",  {31'd0, bus.imem_req}, 32'h1);
    chk("rd_resume_addr", {24'd0, bus.imem_addr}, 32'h01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
